// File: rtl/dict_codec_pkg.sv
// Types shared by the dictionary compressor and decompressor.
// Covers token match types, decompressor FSM states and default widths.
package dict_codec_pkg;

  localparam int DEF_INPUT_WORD = 32;
  localparam int DEF_DICT_ENTRY = 16;
  localparam int DEF_RLE_WIDTH  = 8;

  typedef enum logic [1:0] {
    MT_FULL = 2'b00,
    MT_3B   = 2'b01,
    MT_2B   = 2'b10,
    MT_LIT  = 2'b11
  } match_type_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_EMIT   = 2'b01,
    ST_REPEAT = 2'b10
  } dec_state_e;

endpackage

// File: rtl/dict_mtf_store.sv
// Move-to-front dictionary: one read port, full-match promotion and shift-insert.
module dict_mtf_store
  import dict_codec_pkg::*;
#(
  parameter int W    = DEF_INPUT_WORD,
  parameter int N    = DEF_DICT_ENTRY,
  parameter int LW   = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [LW-1:0] rd_loc,
  output logic [W-1:0]  rd_word,
  input  logic          mtf,
  input  logic          insert,
  input  logic [W-1:0]  ins_word
);

  logic [W-1:0]  entries [N];
  logic [LW-1:0] loc_c;

  // Locations past the last entry alias onto the oldest one.
  always_comb begin
    loc_c = rd_loc;
    if (int'(rd_loc) > N - 1) loc_c = LW'(N - 1);
  end

  assign rd_word = entries[loc_c];

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int i = 0; i < N; i++) entries[i] <= '0;
    end else if (insert) begin
      entries[0] <= ins_word;
      for (int i = 1; i < N; i++) entries[i] <= entries[i-1];
    end else if (mtf) begin
      entries[0] <= entries[loc_c];
      for (int i = 1; i < N; i++)
        if (i <= int'(loc_c)) entries[i] <= entries[i-1];
    end
  end

endmodule

// File: rtl/dict_decompressor.sv
// Token-to-word decompressor: rebuilds words from dictionary matches and
// literals, expands run-length repeats, and keeps the MTF dictionary in step.
//
// state     | meaning
// ST_IDLE   | no output pending
// ST_EMIT   | o_valid high, holding one word
// ST_REPEAT | emitting run-length copies of entry 0
module dict_decompressor
  import dict_codec_pkg::*;
#(
  parameter int INPUT_WORD = DEF_INPUT_WORD,
  parameter int DICT_ENTRY = DEF_DICT_ENTRY,
  parameter int RLE_WIDTH  = DEF_RLE_WIDTH,
  parameter int LOC_W      = $clog2(DICT_ENTRY)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [1:0]            i_type,
  input  logic [LOC_W-1:0]      i_location,
  input  logic                  i_align,
  input  logic [INPUT_WORD-1:0] i_literal,
  input  logic                  i_rle,
  input  logic [RLE_WIDTH-1:0]  i_rle_count,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [INPUT_WORD-1:0] o_word,
  output logic                  o_busy
);

  localparam int W = INPUT_WORD;

  dec_state_e           state;
  logic [RLE_WIDTH-1:0] rep_cnt;
  logic [RLE_WIDTH-1:0] rle_load;
  logic [LOC_W-1:0]     rd_loc;
  logic [W-1:0]         d_word;
  logic [W-1:0]         recon_word;
  logic                 accept;
  logic                 full_match;

  assign o_ready = (state == ST_IDLE) |
                   (((state == ST_EMIT) | ((state == ST_REPEAT) & (rep_cnt == '0))) & i_ready);
  assign o_busy     = (state == ST_REPEAT);
  assign accept     = i_valid & o_ready;
  assign full_match = (match_type_e'(i_type) == MT_FULL);
  assign rd_loc     = i_rle ? '0 : i_location;
  assign rle_load   = (i_rle_count == '0) ? '0 : i_rle_count - RLE_WIDTH'(1);

  always_comb begin
    recon_word = i_literal;
    case (match_type_e'(i_type))
      MT_FULL: recon_word = d_word;
      MT_3B:   recon_word = i_align ? {d_word[W-1:8], i_literal[7:0]}
                                    : {i_literal[W-1:W-8], d_word[W-9:0]};
      MT_2B:   recon_word = i_align ? {d_word[W-1:16], i_literal[15:0]}
                                    : {i_literal[W-1:W-16], d_word[W-17:0]};
      default: recon_word = i_literal;
    endcase
  end

  dict_mtf_store #(.W(W), .N(DICT_ENTRY), .LW(LOC_W)) u_store (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .rd_loc   (rd_loc),
    .rd_word  (d_word),
    .mtf      (accept & ~i_rle & full_match),
    .insert   (accept & ~i_rle & ~full_match),
    .ins_word (recon_word)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state   <= ST_IDLE;
      o_valid <= 1'b0;
      o_word  <= '0;
      rep_cnt <= '0;
    end else if (accept) begin
      o_valid <= 1'b1;
      o_word  <= i_rle ? d_word : recon_word;
      if (i_rle && (rle_load != '0)) begin
        state   <= ST_REPEAT;
        rep_cnt <= rle_load;
      end else begin
        state   <= ST_EMIT;
        rep_cnt <= '0;
      end
    end else begin
      case (state)
        ST_EMIT: begin
          if (i_ready) begin
            state   <= ST_IDLE;
            o_valid <= 1'b0;
          end
        end
        ST_REPEAT: begin
          if (i_ready) begin
            if (rep_cnt != '0) begin
              rep_cnt <= rep_cnt - RLE_WIDTH'(1);
            end else begin
              state   <= ST_IDLE;
              o_valid <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dict_decompressor.sv
// Directed and randomized checks of dict_decompressor against a queue-based
// model of the token rules and move-to-front dictionary.
module tb_dict_decompressor;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [1:0]  i_type = 2'b00;
  logic [3:0]  i_location = 4'd0;
  logic        i_align = 1'b0;
  logic [31:0] i_literal = 32'd0;
  logic        i_rle = 1'b0;
  logic [7:0]  i_rle_count = 8'd0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [31:0] o_word;
  logic        o_busy;

  dict_decompressor dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_type(i_type), .i_location(i_location), .i_align(i_align),
    .i_literal(i_literal), .i_rle(i_rle), .i_rle_count(i_rle_count),
    .o_valid(o_valid), .i_ready(i_ready), .o_word(o_word), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Model: dictionary as a queue (front = most recent), plus the word on the
  // output and how many deliveries of it are still owed.
  logic [31:0] mdl [$];
  logic [31:0] cur = 32'd0;
  int          rem = 0;
  bit          cur_rep = 1'b0;
  int          n_words = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [1:0] t, input logic a,
                                             input logic [31:0] d, input logic [31:0] lit);
    logic [31:0] m;
    case (t)
      2'd0:    m = 32'h0000_0000;
      2'd1:    m = a ? 32'h0000_00FF : 32'hFF00_0000;
      2'd2:    m = a ? 32'h0000_FFFF : 32'hFFFF_0000;
      default: m = 32'hFFFF_FFFF;
    endcase
    return (d & ~m) | (lit & m);
  endfunction

  task automatic model_clear();
    mdl.delete();
    repeat (16) mdl.push_back(32'd0);
    rem = 0;
    cur_rep = 1'b0;
  endtask

  task automatic chk_dict(input string tag);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s dict[%0d]", tag, i), dut.u_store.entries[i], mdl[i]);
  endtask

  // One clock: drive at the falling edge, check, advance the model through
  // the rising edge, end at the next falling edge.
  task automatic cycle(input logic v, input logic r, input logic [1:0] t,
                       input logic [3:0] l, input logic a, input logic [31:0] lit,
                       input logic rl, input logic [7:0] c);
    bit exp_ready;
    logic [31:0] w;
    i_valid = v; i_ready = r; i_type = t; i_location = l; i_align = a;
    i_literal = lit; i_rle = rl; i_rle_count = c;
    #1;
    exp_ready = (rem == 0) || (rem == 1 && r);
    chk("o_ready", 32'(o_ready), 32'(exp_ready));
    chk("o_valid", 32'(o_valid), 32'(rem != 0));
    chk("o_busy", 32'(o_busy), 32'(rem != 0 && cur_rep));
    if (rem != 0) chk("o_word", o_word, cur);
    if (rem != 0 && r) begin
      rem--;
      n_words++;
    end
    if (v && exp_ready) begin
      if (rl) begin
        cur = mdl[0];
        rem = (c == 0) ? 1 : int'(c);
        cur_rep = (c > 1);
      end else begin
        w = model_word(t, a, mdl[l], lit);
        if (t == 2'd0) mdl.delete(int'(l));
        else void'(mdl.pop_back());
        mdl.push_front(w);
        cur = w;
        rem = 1;
        cur_rep = 1'b0;
      end
    end
    @(negedge i_clk);
  endtask

  task automatic lit_tok(input logic [31:0] lit);
    cycle(1'b1, 1'b1, 2'd3, 4'd0, 1'b0, lit, 1'b0, 8'd0);
  endtask

  task automatic idle(input logic r);
    cycle(1'b0, r, 2'd0, 4'd0, 1'b0, 32'd0, 1'b0, 8'd0);
  endtask

  task automatic do_reset(input int n);
    i_reset = 1'b0; i_valid = 1'b0;
    repeat (n) @(negedge i_clk);
    model_clear();
    chk("rst o_valid", 32'(o_valid), 32'd0);
    chk("rst o_word", o_word, 32'd0);
    chk("rst o_busy", 32'(o_busy), 32'd0);
    chk_dict("rst");
    i_reset = 1'b1;
  endtask

  localparam logic [31:0] A = 32'hA1A2A3A4, B = 32'hB1B2B3B4,
                          C = 32'hC1C2C3C4, D = 32'hD1D2D3D4;
  localparam bit PAT [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    model_clear();
    @(negedge i_clk);
    do_reset(2);

    // full match on a cleared dictionary
    cycle(1'b1, 1'b1, 2'd0, 4'd5, 1'b0, 32'hFFFF_FFFF, 1'b0, 8'd0);
    chk("fm5 word", o_word, 32'd0);

    lit_tok(32'hDEADBEEF);
    chk("lit word", o_word, 32'hDEADBEEF);
    cycle(1'b1, 1'b1, 2'd0, 4'd0, 1'b0, 32'd0, 1'b0, 8'd0);
    chk("fm0 word", o_word, 32'hDEADBEEF);
    chk("fm0 dict0", dut.u_store.entries[0], 32'hDEADBEEF);
    chk("fm0 dict1", dut.u_store.entries[1], 32'd0);

    lit_tok(32'h11223344);
    cycle(1'b1, 1'b1, 2'd1, 4'd0, 1'b1, 32'h0000_00AA, 1'b0, 8'd0);
    chk("3b word", o_word, 32'h112233AA);
    cycle(1'b1, 1'b1, 2'd2, 4'd1, 1'b0, 32'hBBCC_0000, 1'b0, 8'd0);
    chk("2b word", o_word, 32'hBBCC3344);
    chk("2b dict0", dut.u_store.entries[0], 32'hBBCC3344);

    lit_tok(A); lit_tok(B); lit_tok(C); lit_tok(D);
    cycle(1'b1, 1'b1, 2'd0, 4'd3, 1'b0, 32'd0, 1'b0, 8'd0);
    chk("mtf word", o_word, A);
    chk("mtf dict0", dut.u_store.entries[0], A);
    chk("mtf dict1", dut.u_store.entries[1], D);
    chk("mtf dict2", dut.u_store.entries[2], C);
    chk("mtf dict3", dut.u_store.entries[3], B);
    chk_dict("mtf");

    // run-length repeat under backpressure
    lit_tok(32'h55);
    cycle(1'b1, 1'b1, 2'd0, 4'd0, 1'b0, 32'd0, 1'b1, 8'd4);
    n_words = 0;
    foreach (PAT[i]) cycle(1'b0, PAT[i], 2'd0, 4'd0, 1'b0, 32'd0, 1'b0, 8'd0);
    chk("rle words", 32'(n_words), 32'd4);
    idle(1'b1);
    chk("rle drained", 32'(o_valid), 32'd0);
    chk_dict("rle");

    // reset while repeating
    cycle(1'b1, 1'b1, 2'd0, 4'd0, 1'b0, 32'd0, 1'b1, 8'd10);
    repeat (3) idle(1'b1);
    do_reset(1);
    repeat (3) idle(1'b1);

    for (int k = 0; k < 600; k++) begin
      automatic logic rl = ($urandom_range(0, 7) == 0);
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), $urandom, rl, 8'($urandom_range(0, 5)));
    end
    chk_dict("rand");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
